muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit feeding the HI/LO registers of the datapath. It replaces the single-step combinational multiply with a sequenced engine. The engine supports signed and unsigned multiply and divide over a configurable operand width, with a start/done handshake. The control sequencer issues `start` in place of the old multiply step, waits for `done`, then drives `hi`/`lo` onto the bus via HIin/LOin.

## Interface
- `WIDTH`, default 32: operand width. Legal values are ≥4 and even. `hi`/`lo` are each WIDTH bits.
- `clk` input 1: single clock, rising edge.
- `clr` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only in IDLE.
- `op` input 2: 00 MUL (signed), 01 MULU, 10 DIV (signed), 11 DIVU. Sampled with `start`.
- `a` input WIDTH: multiplicand / dividend. Sampled with `start`.
- `b` input WIDTH: multiplier / divisor. Sampled with `start`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse. `hi`/`lo`/`div0` are valid while it is high and after.
- `hi` output WIDTH: MUL upper product half; DIV remainder.
- `lo` output WIDTH: MUL lower product half; DIV quotient.
- `div0` output 1: set with `done` when a DIV/DIVU had `b`==0. Cleared on the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1 on a clock edge:
  - Latch `op`, `|a|`, `|b|` (magnitudes for signed ops; raw values for unsigned) and the result signs.
  - Load count = WIDTH and go to CALC.
  - Exception: DIV/DIVU with `b`==0 goes directly to DONE.
- CALC: one iteration per cycle. Count decrements; leave to FIX when count reaches 0 (exactly WIDTH cycles).
  - Multiply: unsigned shift-add, 2·WIDTH-bit accumulator.
  - Divide: unsigned restoring, WIDTH-bit quotient and remainder.
- FIX: one cycle of sign correction.
  - MUL: negate the 2·WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if `a` was negative. The remainder takes the sign of the dividend.
  - Unsigned ops pass through unchanged.
- DONE: one cycle. `hi`/`lo`/`div0` registers update on entry to DONE. `done`=1 in this state. The next state is always IDLE.
- `start` outside IDLE is ignored; no queueing.
- `hi`/`lo`/`div0` hold their value from DONE until the next DONE entry. Internal accumulators are separate registers.
- Divide by zero: `lo` = all ones, `hi` = `a`, `div0`=1.
- Signed overflow (DIV of −2^(WIDTH−1) by −1): `lo` = −2^(WIDTH−1), `hi` = 0. This is the natural result of the magnitude algorithm; no flag is raised.
- `a` = −2^(WIDTH−1): the magnitude is treated as the unsigned value 2^(WIDTH−1). The result is correct for MUL and DIV.

## Timing
- Reset (`clr`=0, asynchronous): state = IDLE. `busy`=0, `done`=0, `div0`=0, `hi`=0, `lo`=0, count=0.
- Reset mid-operation aborts immediately. Release returns to IDLE with no spurious `done`.
- Edge E0 samples `start` in IDLE.
  - Normal op: CALC for edges E1..E_WIDTH, FIX after E_WIDTH, DONE after E_(WIDTH+1). `done` is high during cycle WIDTH+2 after E0 (34 cycles for WIDTH=32).
  - Div-by-zero: `done` is high in the cycle after E0 (latency 1).
- Back-to-back ops: the next `start` can be accepted on the edge that leaves DONE (+1 cycle), i.e. one op every WIDTH+3 cycles.
- `busy` rises in the cycle after E0 and falls in the cycle after DONE.

## Structure
- Shared package `muldiv_pkg`:
  - `op` encodings (OP_MUL, OP_MULU, OP_DIV, OP_DIVU).
  - State enum.
  - A `negate` function (two's-complement, width-generic).
- No sub-module is required. The accumulator shift logic stays inline in `muldiv_unit`.
- The sequencer opcode table maps the existing mul/div opcodes to `op`.

## Test plan (WIDTH=32)
- MUL a=13, b=5 → `done` 34 cycles after the start edge; `hi`=0x00000000, `lo`=0x00000041, `div0`=0.
- MUL a=−3, b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU a=100, b=0 → `done` one cycle after the start edge; `div0`=1, `lo`=0xFFFFFFFF, `hi`=100. The next valid op clears `div0`.
- `start` pulsed while `busy` with different operands → ignored. The result matches the first op, and exactly one `done` pulse occurs.
- `clr` low for 1 cycle during CALC → all outputs 0, `busy`=0. A subsequent MULU 6×7 gives `lo`=42 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide engine:
// opcode encodings, sequencer state codes and a width-generic negate helper.
package muldiv_pkg;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULU = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_DIVU = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Widest value negate handles; callers zero-extend in and truncate out,
   // which is exact for two's complement.
   localparam int unsigned NEG_W = 128;

   function automatic logic [NEG_W-1:0] negate(input logic [NEG_W-1:0] x);
      return ~x + NEG_W'(1);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Sequenced multiply/divide engine: magnitude shift-add / restoring divide
// over WIDTH cycles, then one sign-fix cycle, with a start/done handshake.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   localparam int unsigned AW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [1:0]       op_q, op_d;
   logic             sign_q, sign_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] bmag_q, bmag_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic             div0_d, busy_d, done_d;

   logic             is_div_in, is_signed_in, is_div_q;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum, div_rem, div_diff;
   logic [AW-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Next-state, datapath and output computation
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_d    = op_q;
      sign_d  = sign_q;
      rneg_d  = rneg_q;
      bmag_d  = bmag_q;
      acc_d   = acc_q;
      hi_d    = hi;
      lo_d    = lo;
      div0_d  = div0;

      is_div_in    = (op == OP_DIV) || (op == OP_DIVU);
      is_signed_in = (op == OP_MUL) || (op == OP_DIV);
      is_div_q     = (op_q == OP_DIV) || (op_q == OP_DIVU);
      a_neg        = is_signed_in & a[WIDTH-1];
      b_neg        = is_signed_in & b[WIDTH-1];
      a_mag        = a_neg ? WIDTH'(negate(NEG_W'(a))) : a;
      b_mag        = b_neg ? WIDTH'(negate(NEG_W'(b))) : b;

      // Shift-add step: add multiplier into the upper half, shift right with carry
      mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : {(WIDTH+1){1'b0}});
      // Restoring step: remainder shifted left with the next dividend bit
      div_rem  = acc_q[AW-1:WIDTH-1];
      div_diff = div_rem - {1'b0, bmag_q};

      prod_fix = sign_q ? AW'(negate(NEG_W'(acc_q))) : acc_q;
      quo_fix  = sign_q ? WIDTH'(negate(NEG_W'(acc_q[WIDTH-1:0]))) : acc_q[WIDTH-1:0];
      rem_fix  = rneg_q ? WIDTH'(negate(NEG_W'(acc_q[AW-1:WIDTH]))) : acc_q[AW-1:WIDTH];

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d   = op;
               sign_d = a_neg ^ b_neg;
               rneg_d = a_neg;
               bmag_d = b_mag;
               acc_d  = {WIDTH'(0), a_mag};
               div0_d = 1'b0;
               if (is_div_in && (b == '0)) begin
                  hi_d    = a;
                  lo_d    = '1;
                  div0_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  count_d = CW'(WIDTH);
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            count_d = count_q - CW'(1);
            if (is_div_q) begin
               if (!div_diff[WIDTH])
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (count_q == CW'(1))
               state_d = ST_FIX;
         end
         ST_FIX: begin
            if (is_div_q) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[AW-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         op_q    <= '0;
         sign_q  <= 1'b0;
         rneg_q  <= 1'b0;
         bmag_q  <= '0;
         acc_q   <= '0;
         hi      <= '0;
         lo      <= '0;
         div0    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         sign_q  <= sign_d;
         rneg_q  <= rneg_d;
         bmag_q  <= bmag_d;
         acc_q   <= acc_d;
         hi      <= hi_d;
         lo      <= lo_d;
         div0    <= div0_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        clr;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div0;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .div0  (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic ediv0, input int elat);
      int lat;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      check({tag, " div0_after_start"}, 32'(div0), 32'(ediv0));
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " hi"}, hi, ehi);
      check({tag, " lo"}, lo, elo);
      check({tag, " div0"}, 32'(div0), 32'(ediv0));
      @(posedge clk); #1;
      check({tag, " done_pulse_end"}, 32'(done), 32'd0);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      int cnt0;
      clr = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #1;
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      check("reset div0", 32'(div0), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      clr = 1'b1;

      run_op("mul_13x5",   OP_MUL,  32'd13,        32'd5,         32'h00000000, 32'h00000041, 1'b0, 34);
      run_op("mul_m3x7",   OP_MUL,  32'hFFFFFFFD,  32'd7,         32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
      run_op("mulu_max",   OP_MULU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
      run_op("mul_min_x2", OP_MUL,  32'h80000000,  32'd2,         32'hFFFFFFFF, 32'h00000000, 1'b0, 34);
      run_op("div_m7_2",   OP_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
      run_op("div_7_m2",   OP_DIV,  32'd7,         32'hFFFFFFFE,  32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
      run_op("div_ovf",    OP_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000, 1'b0, 34);
      run_op("div_min_2",  OP_DIV,  32'h80000000,  32'd2,         32'h00000000, 32'hC0000000, 1'b0, 34);
      run_op("divu_by0",   OP_DIVU, 32'd100,       32'd0,         32'd100,      32'hFFFFFFFF, 1'b1, 1);
      run_op("divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd2,        32'd14,       1'b0, 34);

      // start while busy must be ignored
      @(negedge clk);
      start = 1'b1; op = OP_MUL; a = 32'd13; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      cnt0 = done_cnt;
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd99; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ignore done", 32'(done), 32'd1);
      check("ignore hi", hi, 32'h0);
      check("ignore lo", lo, 32'h41);
      check("ignore div0", 32'(div0), 32'd0);
      repeat (8) @(negedge clk);
      check("ignore done_count", 32'(done_cnt - cnt0), 32'd1);
      check("ignore busy_idle", 32'(busy), 32'd0);

      // asynchronous reset during CALC
      @(negedge clk);
      start = 1'b1; op = OP_MULU; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("midreset hi", hi, 32'h0);
      check("midreset lo", lo, 32'h0);
      check("midreset div0", 32'(div0), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      @(negedge clk);
      clr = 1'b1;
      cnt0 = done_cnt;
      repeat (40) @(negedge clk);
      check("midreset no_spurious_done", 32'(done_cnt - cnt0), 32'd0);
      check("midreset busy_after", 32'(busy), 32'd0);

      run_op("mulu_6x7", OP_MULU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
